// File: rtl/i2c_reg_slave.sv
// I2C target with a bank of 16-bit registers addressed by an 8-bit pointer byte.
// SCL/SDA are oversampled on clk; sda is open-drain (driven low or released).
module i2c_reg_slave #(
  parameter logic [6:0]  SLV_ADDR = 7'h40,
  parameter int unsigned IDX_W    = 3,
  parameter logic [15:0] REG0_RST = 16'h399F
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl,
  inout  wire                      sda,
  output logic                     busy,
  output logic                     wr_strobe,
  output logic [IDX_W-1:0]         wr_idx,
  output logic [15:0]              wr_data,
  output logic [16*(2**IDX_W)-1:0] regs_flat
);
  localparam int unsigned NREG = 2**IDX_W;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_PTR, S_WR_MSB, S_WR_LSB, S_WR_EXTRA,
    S_RD_MSB, S_RD_MACK1, S_RD_LSB, S_RD_MACK2, S_WAIT_STOP
  } state_t;

  state_t           r_state;
  logic [1:0]       r_scl_sync, r_sda_sync;
  logic             r_scl_q, r_sda_q;
  logic [2:0]       r_cnt;
  logic [7:0]       r_shift, r_tmp;
  logic             r_byte_done, r_ack, r_mack_n, r_sda_oe;
  logic [IDX_W-1:0] r_ptr;
  logic [15:0]      r_regs [NREG];

  logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic       w_rx_state, w_tx_state, w_mack_state, w_addr_hit;
  logic [7:0] w_rx_byte;
  logic [15:0] w_sel;

  assign sda = r_sda_oe ? 1'b0 : 1'bz;

  assign w_scl        = r_scl_sync[1];
  assign w_sda        = r_sda_sync[1];
  assign w_scl_rise   = w_scl & ~r_scl_q;
  assign w_scl_fall   = ~w_scl & r_scl_q;
  assign w_start      = w_scl & r_scl_q & r_sda_q & ~w_sda;
  assign w_stop       = w_scl & r_scl_q & ~r_sda_q & w_sda;
  assign w_rx_state   = (r_state == S_ADDR) || (r_state == S_PTR) || (r_state == S_WR_MSB) ||
                        (r_state == S_WR_LSB) || (r_state == S_WR_EXTRA);
  assign w_tx_state   = (r_state == S_RD_MSB) || (r_state == S_RD_LSB);
  assign w_mack_state = (r_state == S_RD_MACK1) || (r_state == S_RD_MACK2);
  assign w_addr_hit   = (r_shift[7:1] == SLV_ADDR);
  assign w_rx_byte    = {r_shift[6:0], w_sda};
  assign w_sel        = r_regs[r_ptr];

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[16*g +: 16] = r_regs[g];
  end

  // Two-flop synchronizers plus one delayed copy for edge detection; idle bus is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
      r_sda_sync <= {r_sda_sync[0], sda};
      r_scl_q    <= w_scl;
      r_sda_q    <= w_sda;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_shift     <= 8'h00;
      r_tmp       <= 8'h00;
      r_byte_done <= 1'b0;
      r_ack       <= 1'b0;
      r_mack_n    <= 1'b1;
      r_sda_oe    <= 1'b0;
      r_ptr       <= '0;
      busy        <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_idx      <= '0;
      wr_data     <= 16'h0000;
      for (int i = 0; i < NREG; i++) r_regs[i] <= (i == 0) ? REG0_RST : 16'h0000;
    end else begin
      wr_strobe <= 1'b0;
      if (w_start) begin
        r_state     <= S_ADDR;
        r_cnt       <= 3'd0;
        r_byte_done <= 1'b0;
        r_ack       <= 1'b0;
        r_sda_oe    <= 1'b0;
      end else if (w_stop) begin
        r_state     <= S_IDLE;
        r_byte_done <= 1'b0;
        r_ack       <= 1'b0;
        r_sda_oe    <= 1'b0;
        busy        <= 1'b0;
      end else if (w_rx_state) begin
        if (w_scl_rise && !r_ack) begin
          r_shift <= w_rx_byte;
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_byte_done <= 1'b1;
        end else if (w_scl_fall && r_byte_done) begin
          // Byte complete: open the ACK slot and capture its payload
          r_byte_done <= 1'b0;
          r_ack       <= 1'b1;
          case (r_state)
            S_ADDR: begin
              if (w_addr_hit) begin
                r_sda_oe <= 1'b1;
                busy     <= 1'b1;
              end else begin
                r_state <= S_WAIT_STOP;
                r_ack   <= 1'b0;
                busy    <= 1'b0;
              end
            end
            S_PTR: begin
              r_sda_oe <= 1'b1;
              r_ptr    <= r_shift[IDX_W-1:0];
            end
            S_WR_MSB: begin
              r_sda_oe <= 1'b1;
              r_tmp    <= r_shift;
            end
            S_WR_LSB: r_sda_oe <= 1'b1;
            default: ;
          endcase
        end else if (w_scl_fall && r_ack) begin
          // ACK slot ends: release sda and advance
          r_ack    <= 1'b0;
          r_sda_oe <= 1'b0;
          r_cnt    <= 3'd0;
          case (r_state)
            S_ADDR: begin
              if (r_shift[0]) begin
                r_state  <= S_RD_MSB;
                r_shift  <= w_sel[15:8];
                r_sda_oe <= ~w_sel[15];
              end else begin
                r_state <= S_PTR;
              end
            end
            S_PTR:    r_state <= S_WR_MSB;
            S_WR_MSB: r_state <= S_WR_LSB;
            S_WR_LSB: begin
              r_regs[r_ptr] <= {r_tmp, r_shift};
              wr_strobe     <= 1'b1;
              wr_idx        <= r_ptr;
              wr_data       <= {r_tmp, r_shift};
              r_state       <= S_WR_EXTRA;
            end
            default: ;
          endcase
        end
      end else if (w_tx_state) begin
        if (w_scl_rise) begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_byte_done <= 1'b1;
        end else if (w_scl_fall && r_byte_done) begin
          r_byte_done <= 1'b0;
          r_sda_oe    <= 1'b0;
          r_state     <= (r_state == S_RD_MSB) ? S_RD_MACK1 : S_RD_MACK2;
        end else if (w_scl_fall) begin
          r_shift  <= {r_shift[6:0], 1'b0};
          r_sda_oe <= ~r_shift[6];
        end
      end else if (w_mack_state) begin
        if (w_scl_rise) begin
          r_byte_done <= 1'b1;
          r_mack_n    <= w_sda;
        end else if (w_scl_fall && r_byte_done) begin
          r_byte_done <= 1'b0;
          r_cnt       <= 3'd0;
          if (r_mack_n) begin
            r_state <= S_WAIT_STOP;
            busy    <= 1'b0;
          end else if (r_state == S_RD_MACK1) begin
            r_state  <= S_RD_LSB;
            r_shift  <= w_sel[7:0];
            r_sda_oe <= ~w_sel[7];
          end else begin
            r_state  <= S_RD_MSB;
            r_shift  <= w_sel[15:8];
            r_sda_oe <= ~w_sel[15];
          end
        end
      end
    end
  end
endmodule
